lock_controller: RTL

//   Digital-lock sequencer. It sits directly upstream of the LED blinker and drives its

---
 rtl/lock_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lock_controller.sv
// Digital-lock sequencer: gathers keypad digits, checks or reprograms the stored code,
// and requests error / programming-success blinks from the downstream LED blinker.
module lock_controller #(
  parameter int unsigned               CODE_LEN       = 4,
  parameter int unsigned               DIGIT_W        = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter logic [31:0]               TIMEOUT_CYCLES = 32'd120000000
) (
  input  logic               hwclk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               prog_mode,
  input  logic               lock,
  input  logic               done_blinking,
  output logic               start_blinking,
  output logic               blinkType,
  output logic               unlocked,
  output logic [1:0]         state_dbg
);

  localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COLLECT    = 2'd1,
    CHECK      = 2'd2,
    BLINK_WAIT = 2'd3
  } state_t;

  state_t              state;
  logic [CODE_W-1:0]   code_reg;
  logic [CODE_W-1:0]   entry;
  logic [CNT_W-1:0]    count;
  logic [31:0]         timer;
  logic                blink_acked;

  logic [CODE_W-1:0]   entry_shift;
  logic                last_digit;
  logic                timer_expired;

  // Shift form avoids an out-of-range slice when CODE_LEN is 1.
  assign entry_shift   = (entry << DIGIT_W) | CODE_W'(digit);
  assign last_digit    = (count == CNT_W'(CODE_LEN - 1));
  assign timer_expired = (timer == TIMEOUT_CYCLES - 32'd1);
  assign state_dbg     = state;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state          <= IDLE;
      code_reg       <= DEFAULT_CODE;
      entry          <= '0;
      count          <= '0;
      timer          <= '0;
      blink_acked    <= 1'b0;
      start_blinking <= 1'b0;
      blinkType      <= 1'b0;
      unlocked       <= 1'b0;
    end else begin
      start_blinking <= 1'b0;
      case (state)
        IDLE: begin
          if (lock) begin
            unlocked <= 1'b0;
          end else if (digit_valid) begin
            entry <= entry_shift;
            count <= CNT_W'(1);
            timer <= '0;
            state <= last_digit ? CHECK : COLLECT;
          end
        end

        COLLECT: begin
          if (lock) unlocked <= 1'b0;
          if (digit_valid) begin
            entry <= entry_shift;
            count <= count + CNT_W'(1);
            timer <= '0;
            if (last_digit) state <= CHECK;
          end else if (timer_expired) begin
            entry <= '0;
            count <= '0;
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        CHECK: begin
          if (unlocked && prog_mode) begin
            code_reg       <= entry;
            blinkType      <= 1'b1;
            start_blinking <= 1'b1;
            state          <= BLINK_WAIT;
          end else if (entry == code_reg) begin
            unlocked <= 1'b1;
            state    <= IDLE;
          end else begin
            unlocked       <= 1'b0;
            blinkType      <= 1'b0;
            start_blinking <= 1'b1;
            state          <= BLINK_WAIT;
          end
          entry       <= '0;
          count       <= '0;
          timer       <= '0;
          blink_acked <= 1'b0;
        end

        BLINK_WAIT: begin
          if (lock) unlocked <= 1'b0;
          // Watchdog covers a blinker that never drops or never raises done_blinking.
          if (timer_expired) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 32'd1;
            if (!blink_acked) begin
              if (!done_blinking) blink_acked <= 1'b1;
            end else if (done_blinking) begin
              timer <= '0;
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
